// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes MIPS R/lw/sw/beq/j instructions and writes them
// sequentially into instruction memory with a one-cycle write strobe.
// Optional feature macro: ENCODER_FIELD_CHECK_EN (restricts R-type funct/shamt).
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [6:0]        count,
    output logic              full,
    output logic              err
);

    localparam int unsigned CNT_W = 7;

    localparam logic [2:0] KIND_R   = 3'd0;
    localparam logic [2:0] KIND_LW  = 3'd1;
    localparam logic [2:0] KIND_SW  = 3'd2;
    localparam logic [2:0] KIND_BEQ = 3'd3;
    localparam logic [2:0] KIND_J   = 3'd4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        r_fields_ok;

    // R-type field legality; only restricted when the field check is built in
`ifdef ENCODER_FIELD_CHECK_EN
    always_comb begin
        r_fields_ok = 1'b0;
        if (shamt == 5'd0) begin
            case (funct)
                6'b100000, 6'b100010, 6'b100100,
                6'b100101, 6'b101010: r_fields_ok = 1'b1;
                default:              r_fields_ok = 1'b0;
            endcase
        end
    end
`else
    assign r_fields_ok = 1'b1;
`endif

    // Encode the presented fields and flag illegal kinds or rejected fields
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
        case (in_kind)
            KIND_R: begin
                enc_word  = {OP_R, rs, rt, rd, shamt, funct};
                enc_legal = r_fields_ok;
            end
            KIND_LW: begin
                enc_word  = {OP_LW, rs, rt, imm};
                enc_legal = 1'b1;
            end
            KIND_SW: begin
                enc_word  = {OP_SW, rs, rt, imm};
                enc_legal = 1'b1;
            end
            KIND_BEQ: begin
                enc_word  = {OP_BEQ, rs, rt, imm};
                enc_legal = 1'b1;
            end
            KIND_J: begin
                enc_word  = {OP_J, target};
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = 32'd0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Loader FSM with registered outputs; flush overrides everything but rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= BASE;
            wr_data  <= 32'd0;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            wr_en    <= 1'b0;
            wr_addr  <= BASE;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (enc_legal) begin
                            state    <= WRITE;
                            wr_en    <= 1'b1;
                            wr_data  <= enc_word;
                            in_ready <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_en   <= 1'b0;
                    wr_addr <= wr_addr + ADDR_W'(4);
                    count   <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        state    <= FULL;
                        full     <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                FULL: begin
                    in_ready <= 1'b0;
                    full     <= 1'b1;
                    wr_en    <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    wr_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader with hand-computed expectations.
module tb_instr_encoder_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        flush;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  count;
    logic        full;
    logic        err;

    int errors = 0;
    int checks = 0;

    instr_encoder_loader #(
        .ADDR_W   (8),
        .BASE_ADDR(0),
        .DEPTH    (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_kind (in_kind),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .target  (target),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .count   (count),
        .full    (full),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle
    task automatic send(input logic [2:0] k, input logic [4:0] a_rs, input logic [4:0] a_rt,
                        input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [5:0] a_fn,
                        input logic [15:0] a_imm, input logic [25:0] a_tg);
        in_kind  = k;
        rs       = a_rs;
        rt       = a_rt;
        rd       = a_rd;
        shamt    = a_sh;
        funct    = a_fn;
        imm      = a_imm;
        target   = a_tg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Check the WRITE cycle and the cycle after it
    task automatic expect_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                                input logic [6:0] c);
        check({tag, ".wr_en"},    32'(wr_en), 32'd1);
        check({tag, ".wr_addr"},  32'(wr_addr), 32'(a));
        check({tag, ".wr_data"},  wr_data, d);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, ".wr_en_off"}, 32'(wr_en), 32'd0);
        check({tag, ".count"},     32'(count), 32'(c));
    endtask

    // Pulse flush for one cycle and check the restart state
    task automatic do_flush(input string tag);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check({tag, ".count"},    32'(count), 32'd0);
        check({tag, ".wr_addr"},  32'(wr_addr), 32'd0);
        check({tag, ".full"},     32'(full), 32'd0);
        check({tag, ".wr_en"},    32'(wr_en), 32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_kind = 3'd0;
        rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
        tick();
        tick();
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.wr_en",    32'(wr_en), 32'd0);
        check("rst.wr_addr",  32'(wr_addr), 32'd0);
        check("rst.wr_data",  wr_data, 32'd0);
        check("rst.count",    32'(count), 32'd0);
        check("rst.full",     32'(full), 32'd0);
        check("rst.err",      32'(err), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        // add r3, r1, r2
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0);
        expect_write("add", 8'h00, 32'h0022_1820, 7'd1);
        do_flush("flush1");

        // lw then sw back to back
        send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0);
        expect_write("lw", 8'h00, 32'h8D28_0004, 7'd1);
        send(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0008, 26'h0);
        expect_write("sw", 8'h04, 32'hAD28_0008, 7'd2);
        do_flush("flush2");

        // beq then j
        send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0);
        expect_write("beq", 8'h00, 32'h1022_FFFF, 7'd1);
        send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h000_0010);
        expect_write("j", 8'h04, 32'h0800_0010, 7'd2);

        // illegal kind: err pulse, no write, address kept
        send(3'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0);
        check("ill.err",     32'(err), 32'd1);
        check("ill.wr_en",   32'(wr_en), 32'd0);
        check("ill.wr_addr", 32'(wr_addr), 32'h08);
        check("ill.count",   32'(count), 32'd2);
        tick();
        check("ill.err_off", 32'(err), 32'd0);
        check("ill.wr_en2",  32'(wr_en), 32'd0);
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0);
        expect_write("after_ill", 8'h08, 32'h0022_1820, 7'd3);

        // R-type with funct=0 (sll-style)
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000000, 16'h0, 26'h0);
`ifdef ENCODER_FIELD_CHECK_EN
        check("rchk.err",     32'(err), 32'd1);
        check("rchk.wr_en",   32'(wr_en), 32'd0);
        check("rchk.wr_addr", 32'(wr_addr), 32'h0C);
        tick();
        check("rchk.count",   32'(count), 32'd3);
`else
        expect_write("rfn0", 8'h0C, 32'h0022_1800, 7'd4);
`endif

        // flush coinciding with WRITE drops the pending write
        do_flush("flush3");
        send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h000_0001);
        check("fw.wr_en", 32'(wr_en), 32'd1);
        do_flush("fw");

        // accept coinciding with flush is dropped
        flush = 1'b1;
        send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h000_0002);
        flush = 1'b0;
        check("fa.wr_en", 32'(wr_en), 32'd0);
        tick();
        check("fa.wr_en2", 32'(wr_en), 32'd0);
        check("fa.count",  32'(count), 32'd0);

        // rst mid-write aborts and restores reset values
        send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h000_0003);
        rst = 1'b1;
        tick();
        check("rw.wr_en",    32'(wr_en), 32'd0);
        check("rw.wr_data",  wr_data, 32'd0);
        check("rw.count",    32'(count), 32'd0);
        check("rw.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("rw.in_ready2", 32'(in_ready), 32'd1);

        // fill all 64 words
        for (int i = 0; i < 64; i++) begin
            send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'(i));
            expect_write("fill", 8'(4 * i), 32'h0800_0000 | 32'(i), 7'(i + 1));
            check("fill.full", 32'(full), (i == 63) ? 32'd1 : 32'd0);
        end
        check("full.in_ready", 32'(in_ready), 32'd0);
        check("full.wr_addr",  32'(wr_addr), 32'h00);

        // in_valid ignored while full, no err even for illegal kind
        for (int i = 0; i < 3; i++) begin
            send((i == 0) ? 3'd7 : 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0);
            check("full.err",   32'(err), 32'd0);
            check("full.wr_en", 32'(wr_en), 32'd0);
            check("full.count", 32'(count), 32'd64);
            check("full.full",  32'(full), 32'd1);
        end

        do_flush("flush_full");
        send(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0);
        expect_write("refill", 8'h00, 32'h8D28_0004, 7'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
